gpr: RTL and testbench
======================

GPR -- requirements
Module: gpr

Interface
REQ-001 Parameter WORD_DATA_W, default 32: data word width in bits.
REQ-002 Parameter REG_ADDR_W, default 5: register address width.
REQ-003 Parameter REG_NUM, default 32: number of registers, equal to 2**REG_ADDR_W.
REQ-004 clk  input  1: single clock; all register updates occur on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset (RESET_ENABLE = 0, RESET_DISABLE = 1).
REQ-006 r_addr0  input  REG_ADDR_W: read port 0 address.
REQ-007 r_data0  output  WORD_DATA_W: read port 0 data.
REQ-008 r_addr1  input  REG_ADDR_W: read port 1 address.
REQ-009 r_data1  output  WORD_DATA_W: read port 1 data.
REQ-010 we_  input  1: write enable, active-low (ENABLE_ = 0, DISABLE_ = 1).
REQ-011 w_addr  input  REG_ADDR_W: write address.
REQ-012 w_data  input  WORD_DATA_W: write data.

Function
REQ-013 The block SHALL hold REG_NUM registers of WORD_DATA_W bits each.
REQ-014 On a rising clk edge with reset deasserted and we_ = 0, register[w_addr] SHALL take w_data.
REQ-015 With we_ = 1, no register SHALL change.
REQ-016 Register 0 SHALL be an ordinary writable register, not hardwired to zero.
REQ-017 Both read ports SHALL be combinational, with zero-cycle latency from address to data, and SHALL be independent of each other.
REQ-018 Write bypass: when we_ = 0 and w_addr equals r_addrN, r_dataN SHALL equal w_data in the same cycle, before the clock edge.
REQ-019 Both ports reading the same address SHALL return identical data, including under bypass.
REQ-020 Writes to one address SHALL leave all other addresses unaffected.
REQ-021 Address arithmetic SHALL be unsigned; every REG_ADDR_W value is valid, with no out-of-range case.

Reset
REQ-022 While reset = 0, all registers SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-023 Writes SHALL be ignored while reset = 0, including a write asserted on the same edge as reset.
REQ-024 During reset, the read outputs SHALL show the cleared contents (0) unless write bypass applies. Bypass stays combinational.
REQ-025 Reset asserted mid-operation SHALL discard all prior contents.
REQ-026 After reset deasserts, the first rising edge with we_ = 0 SHALL perform a normal write.

Structure
REQ-027 A shared package/header SHALL define WORD_DATA_W, REG_ADDR_W, REG_NUM, ENABLE_/DISABLE_ and RESET_ENABLE/RESET_DISABLE for reuse by the CPU.
REQ-028 The storage array and write logic SHALL reside in gpr.
REQ-029 Each read port SHALL be one instance of sub-module gpr_read_port, containing the address mux and the bypass compare; it is instantiated twice.
REQ-030 The design SHALL contain no latches. Storage SHALL be flip-flops with asynchronous clear.

Verification
REQ-031 Pulse reset low, then read addresses 0..31 on both ports -> every r_data0 and r_data1 = 0.
REQ-032 For i = 0..31, write i+1 to register i with we_ = 0, then we_ = 1 with r_addr0 = r_addr1 = i on the next cycle -> r_data0 = r_data1 = i+1, including register 0 = 1.
REQ-033 Set we_ = 0, w_addr = 7, w_data = 0xDEADBEEF, r_addr0 = 7, r_addr1 = 3 -> before the edge, r_data0 = 0xDEADBEEF and r_data1 = the old value of register 3.
REQ-034 Drive we_ = 1 with w_addr = 5 and w_data = 0x1234 across an edge -> register 5 is unchanged.
REQ-035 Fill all registers, then assert reset asynchronously between clock edges -> outputs go to 0 without a clock edge, and contents remain 0 after release.
REQ-036 Set r_addr0 = r_addr1 = 31 after writing 0xFFFFFFFF to register 31 -> both ports return 0xFFFFFFFF, and register 30 is unchanged.

Source files
------------

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths and active-low enable/reset encodings for the register file and CPU
package gpr_pkg;
  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM = 2 ** REG_ADDR_W;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;
  localparam logic RESET_DISABLE = 1'b1;
endpackage

// File: rtl/gpr_read_port.sv
// gpr_read_port: combinational register select with same-cycle write bypass
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int WORD_DATA_W = gpr_pkg::WORD_DATA_W,
  parameter int REG_ADDR_W = gpr_pkg::REG_ADDR_W,
  parameter int REG_NUM = 2 ** REG_ADDR_W
) (
  input  logic [REG_NUM-1:0][WORD_DATA_W-1:0] regs,
  input  logic [REG_ADDR_W-1:0]               r_addr,
  input  logic                                we_,
  input  logic [REG_ADDR_W-1:0]               w_addr,
  input  logic [WORD_DATA_W-1:0]              w_data,
  output logic [WORD_DATA_W-1:0]              r_data
);
  // bypass ignores reset so an in-flight write stays visible before the edge
  assign r_data = (we_ == ENABLE_ && w_addr == r_addr) ? w_data : regs[r_addr];
endmodule

// File: rtl/gpr.sv
// gpr: dual-read, single-write register file with async active-low clear and write bypass
module gpr
  import gpr_pkg::*;
#(
  parameter int WORD_DATA_W = gpr_pkg::WORD_DATA_W,
  parameter int REG_ADDR_W = gpr_pkg::REG_ADDR_W,
  parameter int REG_NUM = 2 ** REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  r_addr0,
  output logic [WORD_DATA_W-1:0] r_data0,
  input  logic [REG_ADDR_W-1:0]  r_addr1,
  output logic [WORD_DATA_W-1:0] r_data1,
  input  logic                   we_,
  input  logic [REG_ADDR_W-1:0]  w_addr,
  input  logic [WORD_DATA_W-1:0] w_data
);
  logic [REG_NUM-1:0][WORD_DATA_W-1:0] regs;
  always_ff @(posedge clk or negedge reset)
    if (reset == RESET_ENABLE) regs <= '0;
    else if (we_ == ENABLE_) regs[w_addr] <= w_data;
  gpr_read_port #(.WORD_DATA_W(WORD_DATA_W), .REG_ADDR_W(REG_ADDR_W), .REG_NUM(REG_NUM)) u_rp0 (
    .regs(regs), .r_addr(r_addr0), .we_(we_), .w_addr(w_addr), .w_data(w_data), .r_data(r_data0)
  );
  gpr_read_port #(.WORD_DATA_W(WORD_DATA_W), .REG_ADDR_W(REG_ADDR_W), .REG_NUM(REG_NUM)) u_rp1 (
    .regs(regs), .r_addr(r_addr1), .we_(we_), .w_addr(w_addr), .w_data(w_data), .r_data(r_data1)
  );
endmodule

// File: tb/tb_gpr.sv
// tb_gpr: scoreboard bench for the gpr register file
module tb_gpr;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  r_addr0, r_addr1, w_addr;
  logic [31:0] r_data0, r_data1, w_data;
  logic        we_;
  logic [31:0] model [32];
  logic [31:0] exp0_q[$], exp1_q[$];
  logic [31:0] e0, e1;
  int n_cmp = 0, n_err = 0;

  gpr dut (
    .clk(clk), .reset(reset), .r_addr0(r_addr0), .r_data0(r_data0),
    .r_addr1(r_addr1), .r_data1(r_data1), .we_(we_), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; we_ = 1'b1; w_addr = '0; w_data = '0; r_addr0 = '0; r_addr1 = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      r_addr0 = 5'(i); r_addr1 = 5'(31 - i);
      exp0_q.push_back(model[i]); exp1_q.push_back(model[31 - i]);
      #1;
      e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
      if (r_data0 !== e0) begin n_err++; $display("FAIL reset_clear port0 addr %0d got %h exp %h", i, r_data0, e0); end
      if (r_data1 !== e1) begin n_err++; $display("FAIL reset_clear port1 addr %0d got %h exp %h", 31 - i, r_data1, e1); end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      we_ = 1'b0; w_addr = 5'(i); w_data = 32'(i + 1);
      @(posedge clk); model[i] = 32'(i + 1);
      @(negedge clk);
      we_ = 1'b1; r_addr0 = 5'(i); r_addr1 = 5'(i);
      exp0_q.push_back(model[i]); exp1_q.push_back(model[i]);
      #1;
      e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
      if (r_data0 !== e0) begin n_err++; $display("FAIL write_read port0 addr %0d got %h exp %h", i, r_data0, e0); end
      if (r_data1 !== e1) begin n_err++; $display("FAIL write_read port1 addr %0d got %h exp %h", i, r_data1, e1); end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we_ = 1'b0; w_addr = 5'd7; w_data = 32'hDEADBEEF; r_addr0 = 5'd7; r_addr1 = 5'd3;
    exp0_q.push_back(32'hDEADBEEF); exp1_q.push_back(model[3]);
    #1;
    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
    if (r_data0 !== e0) begin n_err++; $display("FAIL bypass_hit port0 got %h exp %h", r_data0, e0); end
    if (r_data1 !== e1) begin n_err++; $display("FAIL bypass_miss port1 got %h exp %h", r_data1, e1); end
    r_addr1 = 5'd7;
    exp0_q.push_back(32'hDEADBEEF); exp1_q.push_back(32'hDEADBEEF);
    #1;
    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
    if (r_data0 !== e0) begin n_err++; $display("FAIL bypass_both port0 got %h exp %h", r_data0, e0); end
    if (r_data1 !== e1) begin n_err++; $display("FAIL bypass_both port1 got %h exp %h", r_data1, e1); end
    @(posedge clk); model[7] = 32'hDEADBEEF;
    @(negedge clk);
    we_ = 1'b1; w_data = 32'h0; r_addr0 = 5'd7; r_addr1 = 5'd6;
    exp0_q.push_back(model[7]); exp1_q.push_back(model[6]);
    #1;
    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
    if (r_data0 !== e0) begin n_err++; $display("FAIL bypass_commit port0 got %h exp %h", r_data0, e0); end
    if (r_data1 !== e1) begin n_err++; $display("FAIL bypass_neighbor port1 got %h exp %h", r_data1, e1); end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    we_ = 1'b1; w_addr = 5'd5; w_data = 32'h1234; r_addr0 = 5'd5; r_addr1 = 5'd5;
    exp0_q.push_back(model[5]);
    #1;
    e0 = exp0_q.pop_front(); n_cmp++;
    if (r_data0 !== e0) begin n_err++; $display("FAIL no_bypass_disabled port0 got %h exp %h", r_data0, e0); end
    @(negedge clk);
    exp0_q.push_back(model[5]); exp1_q.push_back(model[5]);
    #1;
    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
    if (r_data0 !== e0) begin n_err++; $display("FAIL no_write port0 got %h exp %h", r_data0, e0); end
    if (r_data1 !== e1) begin n_err++; $display("FAIL no_write port1 got %h exp %h", r_data1, e1); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      we_ = 1'b0; w_addr = 5'(i); w_data = $urandom | 32'h1;
      @(posedge clk); model[i] = w_data;
    end
    @(negedge clk);
    we_ = 1'b1; r_addr0 = 5'd4; r_addr1 = 5'd9;
    #2 reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp0_q.push_back(model[4]); exp1_q.push_back(model[9]);
    #1;
    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
    if (r_data0 !== e0) begin n_err++; $display("FAIL async_clear port0 got %h exp %h", r_data0, e0); end
    if (r_data1 !== e1) begin n_err++; $display("FAIL async_clear port1 got %h exp %h", r_data1, e1); end
    @(negedge clk);
    we_ = 1'b0; w_addr = 5'd4; w_data = 32'hA5A5_0F0F;
    exp0_q.push_back(32'hA5A5_0F0F); exp1_q.push_back(model[9]);
    #1;
    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
    if (r_data0 !== e0) begin n_err++; $display("FAIL reset_bypass port0 got %h exp %h", r_data0, e0); end
    if (r_data1 !== e1) begin n_err++; $display("FAIL reset_bypass port1 got %h exp %h", r_data1, e1); end
    @(negedge clk);
    we_ = 1'b1;
    exp0_q.push_back(model[4]);
    #1;
    e0 = exp0_q.pop_front(); n_cmp++;
    if (r_data0 !== e0) begin n_err++; $display("FAIL reset_write_ignored port0 got %h exp %h", r_data0, e0); end
    #1 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      r_addr0 = 5'(i); r_addr1 = 5'(i ^ 5'h15);
      exp0_q.push_back(model[i]); exp1_q.push_back(model[i ^ 5'h15]);
      #1;
      e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
      if (r_data0 !== e0) begin n_err++; $display("FAIL post_reset port0 addr %0d got %h exp %h", i, r_data0, e0); end
      if (r_data1 !== e1) begin n_err++; $display("FAIL post_reset port1 addr %0d got %h exp %h", i ^ 5'h15, r_data1, e1); end
    end
    @(negedge clk);
    we_ = 1'b0; w_addr = 5'd2; w_data = 32'h55;
    @(posedge clk); model[2] = 32'h55;
    @(negedge clk);
    we_ = 1'b1; r_addr0 = 5'd2; r_addr1 = 5'd2;
    exp0_q.push_back(model[2]);
    #1;
    e0 = exp0_q.pop_front(); n_cmp++;
    if (r_data0 !== e0) begin n_err++; $display("FAIL first_write_after_reset got %h exp %h", r_data0, e0); end
  endtask

  task automatic test_max_addr();
    @(negedge clk);
    we_ = 1'b0; w_addr = 5'd30; w_data = 32'h3030_3030;
    @(posedge clk); model[30] = 32'h3030_3030;
    @(negedge clk);
    w_addr = 5'd31; w_data = 32'hFFFF_FFFF;
    @(posedge clk); model[31] = 32'hFFFF_FFFF;
    @(negedge clk);
    we_ = 1'b1; r_addr0 = 5'd31; r_addr1 = 5'd31;
    exp0_q.push_back(model[31]); exp1_q.push_back(model[31]);
    #1;
    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); n_cmp += 2;
    if (r_data0 !== e0) begin n_err++; $display("FAIL max_addr port0 got %h exp %h", r_data0, e0); end
    if (r_data1 !== e1) begin n_err++; $display("FAIL max_addr port1 got %h exp %h", r_data1, e1); end
    r_addr0 = 5'd30;
    exp0_q.push_back(model[30]);
    #1;
    e0 = exp0_q.pop_front(); n_cmp++;
    if (r_data0 !== e0) begin n_err++; $display("FAIL neighbor_30 got %h exp %h", r_data0, e0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_no_write();
    test_async_reset();
    test_max_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
